// File: rtl/pipe_shifter_if.sv
// Operand/result handshake bundle for pipe_shifter: valid/ready in, valid/ready out.
// The master modport is the producer/consumer side; the slave modport is the shifter.
interface pipe_shifter_if #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
);
   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_amt;
   logic [1:0]       in_op;
   logic [TAG_W-1:0] in_tag;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [TAG_W-1:0] out_tag;
   logic             out_zero;

   modport master (
      output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_zero
   );

   modport slave (
      input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_zero
   );
endinterface

// File: rtl/pipe_shifter.sv
// Pipelined log-barrel shifter (SLL/SRL/SRA, optional ROR) with valid/ready flow control.
// Define SHIFTER_ROR_EN to make op 2'b11 rotate right; otherwise op 2'b11 behaves as SRL.
module pipe_shifter #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2,
   parameter int TAG_W  = 4
) (
   input logic          clk,
   input logic          rst_n,
   pipe_shifter_if.slave bus
);
   localparam int SHW   = $clog2(WIDTH);
   localparam int BASE  = SHW / STAGES;
   localparam int EXTRA = SHW % STAGES;
   localparam logic [WIDTH-1:0] ONES = '1;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROR = 2'b11
   } op_e;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SHW-1:0]   amt;
      op_e              op;
      logic             sign;
      logic [TAG_W-1:0] tag;
   } slot_t;

   // Mux levels are dealt out in order; the first EXTRA stages take one more level.
   function automatic int level_lo(input int k);
      return k * BASE + ((k < EXTRA) ? k : EXTRA);
   endfunction

   function automatic int level_cnt(input int k);
      return BASE + ((k < EXTRA) ? 1 : 0);
   endfunction

   function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                    input op_e op,
                                                    input logic sign,
                                                    input int s);
      logic [WIDTH-1:0] r;
      case (op)
         OP_SLL:  r = d << s;
         OP_SRA:  r = (d >> s) | ({WIDTH{sign}} & ~(ONES >> s));
`ifdef SHIFTER_ROR_EN
         OP_ROR:  r = (d >> s) | (d << (WIDTH - s));
`endif
         default: r = d >> s;
      endcase
      return r;
   endfunction

   slot_t             slot_q  [STAGES];
   slot_t             slot_in [STAGES];
   slot_t             slot_nx [STAGES];
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] vin;
   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] ld;
   logic              zero_q;

   // NOTE: every signal written in an always_comb gets a value before any condition,
   // otherwise a path that skips the assignment infers a latch.
   always_comb begin
      slot_in[0] = '{data: bus.in_data, amt: bus.in_amt, op: op_e'(bus.in_op),
                     sign: bus.in_data[WIDTH-1], tag: bus.in_tag};
      vin[0]     = bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
         slot_in[k] = slot_q[k-1];
         vin[k]     = v_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         slot_nx[k] = slot_in[k];
         for (int i = 0; i < SHW; i++) begin
            if (i >= level_lo(k) && i < level_lo(k) + level_cnt(k) && slot_in[k].amt[i])
               slot_nx[k].data = shift_level(slot_nx[k].data, slot_in[k].op,
                                             slot_in[k].sign, 1 << i);
         end
      end
   end

   // A slot advances when its successor is empty or itself advancing; the last
   // slot advances on out_ready, so back-pressure ripples combinationally to in_ready.
   always_comb begin
      adv           = '0;
      adv[STAGES-1] = bus.out_ready;
      for (int k = STAGES - 2; k >= 0; k--)
         adv[k] = !v_q[k+1] || adv[k+1];
      ld = ~v_q | adv;
   end

   // NOTE: the slot payloads are reset too, because the last slot drives out_data
   // and out_tag directly and those must read zero while the pipe is in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q    <= '0;
         zero_q <= 1'b1;
         for (int k = 0; k < STAGES; k++)
            slot_q[k] <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (ld[k]) begin
               v_q[k] <= vin[k];
               if (vin[k])
                  slot_q[k] <= slot_nx[k];
            end
         end
         if (ld[STAGES-1] && vin[STAGES-1])
            zero_q <= (slot_nx[STAGES-1].data == '0);
      end
   end

   assign bus.in_ready  = ld[0];
   assign bus.out_valid = v_q[STAGES-1];
   assign bus.out_data  = slot_q[STAGES-1].data;
   assign bus.out_tag   = slot_q[STAGES-1].tag;
   assign bus.out_zero  = zero_q;
endmodule
